// File: rtl/bus_sequencer_if.sv
// rtl/bus_sequencer_if.sv - core-side and pin-side signals of the external bus sequencer
interface bus_sequencer_if;
  logic [15:0] address;
  logic        rw;
  logic [7:0]  data_out;
  logic [7:0]  data_in;
  logic        clk_enable;
  logic        mem_ready;
  logic [7:0]  uo_out;
  logic        ale_lo;
  logic        ale_hi;
  logic        we_n;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;

  modport master (
    input  address, rw, data_out, mem_ready, uio_in,
    output data_in, clk_enable, uo_out, ale_lo, ale_hi, we_n, uio_out, uio_oe
  );

  modport slave (
    output address, rw, data_out, mem_ready, uio_in,
    input  data_in, clk_enable, uo_out, ale_lo, ale_hi, we_n, uio_out, uio_oe
  );
endinterface

// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - five-phase multiplexed bus sequencer stepping the 6502 core once per cycle
module bus_sequencer #(
  parameter logic [7:0] READ_RESET_VALUE = 8'hEA
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  bus_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    P_SAMPLE = 3'd0,
    P_ADL    = 3'd1,
    P_ADH    = 3'd2,
    P_DATA   = 3'd3,
    P_STEP   = 3'd4
  } phase_t;

  phase_t      state;
  logic [15:0] addr_q;
  logic        rw_q;
  logic [7:0]  wdata_q;
  logic [7:0]  data_in_q;
  logic [7:0]  uo_q;
  logic        ale_lo_q;
  logic        ale_hi_q;
  logic        we_n_q;
  logic [7:0]  oe_q;
  logic        clk_en_q;

  assign bus.data_in    = data_in_q;
  assign bus.clk_enable = clk_en_q;
  assign bus.uo_out     = uo_q;
  assign bus.ale_lo     = ale_lo_q;
  assign bus.ale_hi     = ale_hi_q;
  assign bus.we_n       = we_n_q;
  assign bus.uio_out    = wdata_q;
  assign bus.uio_oe     = oe_q;

  // Outputs are registered for the phase being entered, so every pin comes from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= P_SAMPLE;
      addr_q    <= 16'h0000;
      rw_q      <= 1'b1;
      wdata_q   <= 8'h00;
      data_in_q <= READ_RESET_VALUE;
      uo_q      <= 8'h00;
      ale_lo_q  <= 1'b0;
      ale_hi_q  <= 1'b0;
      we_n_q    <= 1'b1;
      oe_q      <= 8'h00;
      clk_en_q  <= 1'b0;
    end else if (!ena) begin
      clk_en_q <= 1'b0;
    end else begin
      case (state)
        P_SAMPLE: begin
          addr_q   <= bus.address;
          rw_q     <= bus.rw;
          wdata_q  <= bus.data_out;
          uo_q     <= bus.address[7:0];
          ale_lo_q <= 1'b1;
          state    <= P_ADL;
        end
        P_ADL: begin
          uo_q     <= addr_q[15:8];
          ale_lo_q <= 1'b0;
          ale_hi_q <= 1'b1;
          state    <= P_ADH;
        end
        P_ADH: begin
          ale_hi_q <= 1'b0;
          oe_q     <= rw_q ? 8'h00 : 8'hFF;
          we_n_q   <= rw_q;
          state    <= P_DATA;
        end
        P_DATA: begin
          if (bus.mem_ready) begin
            if (rw_q) begin
              data_in_q <= bus.uio_in;
            end
            we_n_q   <= 1'b1;
            clk_en_q <= 1'b1;
            state    <= P_STEP;
          end
        end
        P_STEP: begin
          // A freeze inside P_STEP drops the pulse; re-raise it once on resume so the core still steps.
          if (clk_en_q) begin
            clk_en_q <= 1'b0;
            oe_q     <= 8'h00;
            state    <= P_SAMPLE;
          end else begin
            clk_en_q <= 1'b1;
          end
        end
        default: begin
          state <= P_SAMPLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// tb/tb_bus_sequencer.sv - directed vector bench for bus_sequencer
module tb_bus_sequencer;

  logic clk;
  logic rst_n;
  logic ena;

  bus_sequencer_if bus ();

  bus_sequencer #(.READ_RESET_VALUE(8'hEA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [7:0]  exp_din;
  } vec_t;

  vec_t       vecs [6];
  int         n_tests;
  int         n_fail;
  logic [7:0] prev_hi;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered at the negedge of a P_SAMPLE clock; returns at the negedge of the next P_SAMPLE clock.
  task automatic run_cycle(input vec_t v);
    bus.address   = v.addr;
    bus.rw        = v.rw;
    bus.data_out  = v.wdata;
    bus.uio_in    = v.rdata;
    bus.mem_ready = 1'b1;
    chk("c1_ale_lo", 16'(bus.ale_lo), 16'(1'b0));
    chk("c1_ale_hi", 16'(bus.ale_hi), 16'(1'b0));
    chk("c1_we_n", 16'(bus.we_n), 16'(1'b1));
    chk("c1_uio_oe", 16'(bus.uio_oe), 16'h00);
    chk("c1_uo_hold", 16'(bus.uo_out), 16'(prev_hi));
    step();
    chk("c2_uo_adl", 16'(bus.uo_out), 16'(v.addr[7:0]));
    chk("c2_ale_lo", 16'(bus.ale_lo), 16'(1'b1));
    chk("c2_ale_hi", 16'(bus.ale_hi), 16'(1'b0));
    step();
    chk("c3_uo_adh", 16'(bus.uo_out), 16'(v.addr[15:8]));
    chk("c3_ale_hi", 16'(bus.ale_hi), 16'(1'b1));
    chk("c3_ale_lo", 16'(bus.ale_lo), 16'(1'b0));
    step();
    chk("c4_uio_oe", 16'(bus.uio_oe), v.rw ? 16'h00 : 16'hFF);
    chk("c4_we_n", 16'(bus.we_n), 16'(v.rw));
    chk("c4_clk_en", 16'(bus.clk_enable), 16'(1'b0));
    if (!v.rw) chk("c4_uio_out", 16'(bus.uio_out), 16'(v.wdata));
    step();
    chk("c5_clk_en", 16'(bus.clk_enable), 16'(1'b1));
    chk("c5_data_in", 16'(bus.data_in), 16'(v.exp_din));
    chk("c5_we_n", 16'(bus.we_n), 16'(1'b1));
    chk("c5_uio_oe", 16'(bus.uio_oe), v.rw ? 16'h00 : 16'hFF);
    prev_hi = v.addr[15:8];
    step();
    chk("next_clk_en", 16'(bus.clk_enable), 16'(1'b0));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    prev_hi = 8'h00;
    vecs[0] = '{addr: 16'h1234, rw: 1'b1, wdata: 8'h00, rdata: 8'hA5, exp_din: 8'hA5};
    vecs[1] = '{addr: 16'h00FF, rw: 1'b0, wdata: 8'h5A, rdata: 8'h11, exp_din: 8'hA5};
    vecs[2] = '{addr: 16'hFFFF, rw: 1'b1, wdata: 8'h66, rdata: 8'h00, exp_din: 8'h00};
    vecs[3] = '{addr: 16'h0000, rw: 1'b0, wdata: 8'hFF, rdata: 8'h22, exp_din: 8'h00};
    vecs[4] = '{addr: 16'h8001, rw: 1'b1, wdata: 8'h00, rdata: 8'h3C, exp_din: 8'h3C};
    vecs[5] = '{addr: 16'h0000, rw: 1'b1, wdata: 8'h81, rdata: 8'hFF, exp_din: 8'hFF};

    rst_n         = 1'b0;
    ena           = 1'b1;
    bus.address   = 16'h0000;
    bus.rw        = 1'b1;
    bus.data_out  = 8'h00;
    bus.uio_in    = 8'h00;
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_uo_out", 16'(bus.uo_out), 16'h00);
    chk("rst_uio_out", 16'(bus.uio_out), 16'h00);
    chk("rst_uio_oe", 16'(bus.uio_oe), 16'h00);
    chk("rst_ale", {14'd0, bus.ale_hi, bus.ale_lo}, 16'd0);
    chk("rst_we_n", 16'(bus.we_n), 16'(1'b1));
    chk("rst_clk_en", 16'(bus.clk_enable), 16'(1'b0));
    chk("rst_data_in", 16'(bus.data_in), 16'h00EA);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_cycle(vecs[i]);

    // Address and rw changed during P_ADL must not reach the bus this cycle.
    bus.address = 16'h1234; bus.rw = 1'b1; bus.data_out = 8'h00; bus.uio_in = 8'h77; bus.mem_ready = 1'b1;
    step();
    bus.address = 16'hABCD; bus.rw = 1'b0;
    chk("late_adl", 16'(bus.uo_out), 16'h34);
    step();
    chk("late_adh", 16'(bus.uo_out), 16'h12);
    step();
    chk("late_oe", 16'(bus.uio_oe), 16'h00);
    chk("late_we_n", 16'(bus.we_n), 16'(1'b1));
    step();
    chk("late_din", 16'(bus.data_in), 16'h77);
    step();
    prev_hi = 8'h12;
    run_cycle('{addr: 16'hABCD, rw: 1'b1, wdata: 8'h00, rdata: 8'h42, exp_din: 8'h42});

    // Three wait states: mem_ready low at the edges ending clocks 4, 5 and 6.
    bus.address = 16'h2468; bus.rw = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      bus.mem_ready = (n >= 7);
      bus.uio_in    = (n >= 7) ? 8'hC3 : 8'h11;
      chk($sformatf("wait_clk_en_c%0d", n), 16'(bus.clk_enable), 16'(n == 8));
      if (n == 4) chk("wait_c4_uo", 16'(bus.uo_out), 16'h24);
      if (n == 8) chk("wait_din", 16'(bus.data_in), 16'h00C3);
      if (n < 9) step();
    end
    prev_hi = 8'h24;

    // ena low during P_ADH for four edges.
    bus.address = 16'h5678; bus.rw = 1'b1; bus.uio_in = 8'h9E; bus.mem_ready = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      if (n == 3) ena = 1'b0;
      if (n == 7) ena = 1'b1;
      chk($sformatf("frz_clk_en_c%0d", n), 16'(bus.clk_enable), 16'(n == 9));
      if (n >= 3 && n <= 7) begin
        chk($sformatf("frz_uo_c%0d", n), 16'(bus.uo_out), 16'h56);
        chk($sformatf("frz_ale_hi_c%0d", n), 16'(bus.ale_hi), 16'(1'b1));
      end
      if (n == 9) chk("frz_din", 16'(bus.data_in), 16'h009E);
      if (n < 10) step();
    end
    prev_hi = 8'h56;

    // Reset asserted while a write is stalled in P_DATA.
    bus.address = 16'h4321; bus.rw = 1'b0; bus.data_out = 8'h99; bus.mem_ready = 1'b1;
    step(); step(); step();
    bus.mem_ready = 1'b0;
    chk("pre_rst_we_n", 16'(bus.we_n), 16'(1'b0));
    chk("pre_rst_oe", 16'(bus.uio_oe), 16'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_oe", 16'(bus.uio_oe), 16'h00);
    chk("mid_rst_we_n", 16'(bus.we_n), 16'(1'b1));
    chk("mid_rst_din", 16'(bus.data_in), 16'h00EA);
    chk("mid_rst_clk_en", 16'(bus.clk_enable), 16'(1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.address = 16'h0000; bus.rw = 1'b1; bus.uio_in = 8'h00; bus.mem_ready = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      chk($sformatf("post_rst_clk_en_c%0d", n), 16'(bus.clk_enable), 16'(n == 5));
      if (n < 5) step();
    end
    chk("post_rst_din", 16'(bus.data_in), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
